fifo_write_arbiter: RTL
=======================

Name: fifo_write_arbiter

Overview:
- Shares the single write port of the asynchronous FIFO among NUM_REQ producers in the W_CLK domain.
- Round-robin grant per burst: a granted requester owns the port until it sends a LAST beat or reaches MAX_BURST beats.
- Honours FIFO FULL back-pressure.
- Drives I_DATA/W_EN of the FIFO directly; sits between the producers and the write side of the FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- data_width, 9, FIFO data width; must match the FIFO instance.
- MAX_BURST, 16, maximum beats per grant (power of 2, >=2).

Ports:
- W_CLK  input  1  write-domain clock.
- WRST_n  input  1  asynchronous active-low reset.
- REQ_VALID  input  NUM_REQ  per-requester beat valid.
- REQ_DATA  input  NUM_REQ*data_width  per-requester data; requester i occupies bits [i*data_width +: data_width].
- REQ_LAST  input  NUM_REQ  marks the final beat of a packet.
- REQ_READY  output  NUM_REQ  beat accepted this cycle (one-hot or zero).
- FULL  input  1  from the FIFO write-pointer handler.
- W_EN  output  1  FIFO write enable.
- I_DATA  output  data_width  FIFO write data.
- GNT  output  NUM_REQ  registered one-hot current owner; 0 in IDLE.
- BUSY  output  1  state==BURST.

Behaviour:
- Reset (async, WRST_n=0): state=IDLE, GNT=0, last-served pointer=NUM_REQ-1 (so requester 0 wins first), beat_cnt=0. Combinational results: W_EN=0, REQ_READY=0, I_DATA=0.
- FSM states: IDLE, BURST.
- IDLE:
  - If any REQ_VALID, pick the first set bit searching upward from (last+1) mod NUM_REQ with wrap.
  - Register GNT one-hot, set beat_cnt=0, go to BURST next edge.
  - No beat transfers in IDLE, so each burst costs one arbitration bubble.
- BURST, with g = granted index:
  - beat = REQ_VALID[g] & ~FULL.
  - W_EN = beat; REQ_READY[g] = beat; I_DATA = REQ_DATA slice g (combinational mux, zero-latency).
  - Outside BURST, I_DATA=0.
  - On a beat, beat_cnt increments.
  - If REQ_LAST[g] or beat_cnt==MAX_BURST-1 on that beat: last<=g, GNT<=0, go to IDLE.
  - A burst truncated by MAX_BURST re-arbitrates. The requester continues its packet on its next grant.
- Owner drops REQ_VALID mid-burst: stay in BURST holding the grant. No timeout; the packet stays contiguous in the FIFO.
- FULL high: W_EN=0 and REQ_READY=0; state, GNT and beat_cnt hold. FULL is sampled combinationally, so no overflow is possible.
- Requests arriving while BURST is active are ignored until IDLE.
- Only requesters whose REQ_VALID=1 in the IDLE cycle are eligible. A single requester re-wins every other cycle.
- Reset mid-burst: the partial packet is abandoned; FIFO contents are not this block's concern.
- beat_cnt width: $clog2(MAX_BURST). It never wraps, because it is cleared on exit.
- Requesters must hold REQ_DATA/REQ_LAST stable while VALID & ~READY.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds output STAT_BEATS (NUM_REQ*16): per-requester saturating beat counters, incremented on each accepted beat.
  - Adds output STAT_STALL (16): saturating count of BURST cycles with REQ_VALID[g]&FULL.
  - All counters reset to 0 and saturate at 16'hFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_arb_pkg:
  - typedef enum logic {IDLE, BURST} arb_state_t
  - STAT_W=16
  - function rr_pick(req, last) returning one-hot.
- One sub-module: rr_priority_picker, a combinational rotate / find-first / rotate-back, parameterised by NUM_REQ. Reusable on the read side.

Test Plan:
- Reset then REQ_VALID=4'b1111, all LAST=1 on the first beat → grants in order 0,1,2,3,0; one W_EN every 2 cycles; I_DATA equals each requester's value.
- Requester 2 only, 40-beat packet with MAX_BURST=16 → bursts of 16,16,8 beats with a 1-cycle GNT=0 gap between them; 40 writes total.
- During a burst of requester 1, FULL=1 for 5 cycles → W_EN=0 and REQ_READY=0 for those 5 cycles; GNT holds 4'b0010; resumes with no lost or duplicated beat.
- Requester 0 owner drops VALID for 3 cycles mid-packet while requester 3 is valid → GNT stays 4'b0001; requester 3 is granted only after requester 0's LAST.
- Assert WRST_n=0 asynchronously mid-burst (between clock edges) → GNT=0, W_EN=0 immediately; after release with all requesting, requester 0 wins first.
- With FIFO_ARB_STATS_EN: 10 beats from requester 1, 3 FULL-stall cycles → STAT_BEATS[1]=10, others 0, STAT_STALL=3.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and round-robin helper for the FIFO write-port arbiter.
// Optional statistics are enabled by defining FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STAT_W  = 16;
    localparam int MAX_REQ = 8;

    // Rotate so (last+1) sits at bit 0, keep the lowest set bit, rotate back.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        last,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] rot;
        logic [MAX_REQ-1:0] first;
        logic [MAX_REQ-1:0] gnt;
        logic [2:0]         pos;
        int unsigned        sh;
        rot   = '0;
        gnt   = '0;
        sh    = (last + 1) % n;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos    = 3'((sh + k) % n);
            rot[k] = (k < n) ? req[pos] : 1'b0;
        end
        first = rot & (~rot + 1'b1);
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = 3'((sh + k) % n);
            if (k < n && first[k]) begin
                gnt[pos] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: one-hot grant and its index, searching
// upward from the requester after last_i with wrap-around.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] gnt_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        gnt_ext                = rr_pick(req_ext, 32'(last_i), NUM_REQ);
        gnt_o                  = gnt_ext[NUM_REQ-1:0];
        idx_o                  = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (gnt_ext[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NUM_REQ
// producers. Define FIFO_ARB_STATS_EN to add beat/stall statistics outputs.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int data_width = 9,
    parameter int MAX_BURST  = 16
) (
    input  logic                           W_CLK,
    input  logic                           WRST_n,
    input  logic [NUM_REQ-1:0]             REQ_VALID,
    input  logic [NUM_REQ*data_width-1:0]  REQ_DATA,
    input  logic [NUM_REQ-1:0]             REQ_LAST,
    output logic [NUM_REQ-1:0]             REQ_READY,
    input  logic                           FULL,
    output logic                           W_EN,
    output logic [data_width-1:0]          I_DATA,
    output logic [NUM_REQ-1:0]             GNT,
    output logic                           BUSY
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]      STAT_BEATS,
    output logic [STAT_W-1:0]              STAT_STALL
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST);

    arb_state_t          state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [IDX_W-1:0]    gidx_q;
    logic [IDX_W-1:0]    last_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                in_burst;
    logic                owner_vld;
    logic                beat;
    logic                burst_end;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (REQ_VALID),
        .last_i  (last_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx)
    );

    // FULL gates the beat combinationally so a write can never hit a full FIFO.
    always_comb begin
        in_burst  = (state_q == BURST);
        owner_vld = REQ_VALID[gidx_q];
        beat      = in_burst & owner_vld & ~FULL;
        burst_end = beat & (REQ_LAST[gidx_q] | (cnt_q == CNT_W'(MAX_BURST - 1)));
    end

    assign W_EN      = beat;
    assign REQ_READY = beat ? gnt_q : '0;
    assign I_DATA    = in_burst ? REQ_DATA[gidx_q*data_width +: data_width] : '0;
    assign GNT       = gnt_q;
    assign BUSY      = in_burst;

    always_ff @(posedge W_CLK or negedge WRST_n) begin
        if (!WRST_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|REQ_VALID) begin
                        gnt_q   <= pick_gnt;
                        gidx_q  <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        last_q  <= gidx_q;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (beat) begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] beats_q [NUM_REQ];
    logic [STAT_W-1:0] beats_d [NUM_REQ];
    logic [STAT_W-1:0] stall_q;
    logic [STAT_W-1:0] stall_d;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        beats_d = beats_q;
        stall_d = stall_q;
        if (beat) begin
            beats_d[gidx_q] = sat_inc(beats_q[gidx_q]);
        end
        if (in_burst && owner_vld && FULL) begin
            stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge W_CLK or negedge WRST_n) begin
        if (!WRST_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                beats_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            beats_q <= beats_d;
            stall_q <= stall_d;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        assign STAT_BEATS[i*STAT_W +: STAT_W] = beats_q[i];
    end
    assign STAT_STALL = stall_q;
`endif

endmodule
